cache_controller: RTL



---
 rtl/cache_controller_pkg.sv | 15 +
 rtl/cache_controller_set_array.sv | 71 +++++++
 rtl/cache_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared widths and FSM encoding for the data cache controller
package cache_controller_pkg;
    localparam int LEN_ADDRESS     = 32;
    localparam int LEN_REGISTER    = 32;
    localparam int SETS            = 64;
    localparam int LEN_CACHE_INDEX = 6;
    localparam int LEN_CACHE_TAG   = 10;
    localparam int LEN_CACHE_LINE  = 64;
    localparam int TAG_W           = LEN_CACHE_TAG;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_e;
endpackage

// File: rtl/cache_controller_set_array.sv
// cache_set_array: 2-way tag/data storage with LRU bits, combinational lookup, synchronous fill/word-write/LRU update
module cache_set_array import cache_controller_pkg::*; (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_CACHE_INDEX-1:0] index,
    input  logic [TAG_W-1:0]           tag,
    input  logic                       word_sel,
    input  logic                       fill_en,
    input  logic [LEN_CACHE_LINE-1:0]  fill_line,
    input  logic                       wr_en,
    input  logic [LEN_REGISTER-1:0]    wr_word,
    input  logic                       touch_en,
    output logic                       hit,
    output logic                       hit_way,
    output logic [LEN_REGISTER-1:0]    rd_word
);
    logic [SETS-1:0]           valid_q [2];
    logic [SETS-1:0]           valid_d [2];
    logic [TAG_W-1:0]          tag_q   [2][SETS];
    logic [TAG_W-1:0]          tag_d   [2][SETS];
    logic [LEN_CACHE_LINE-1:0] data_q  [2][SETS];
    logic [LEN_CACHE_LINE-1:0] data_d  [2][SETS];
    logic [SETS-1:0]           lru_q, lru_d;
    logic                      hit0, hit1, victim;
    logic [LEN_CACHE_LINE-1:0] line;

    // Lookup: way 0 wins if both ways ever matched
    always_comb begin
        hit0    = valid_q[0][index] && (tag_q[0][index] == tag);
        hit1    = valid_q[1][index] && (tag_q[1][index] == tag);
        hit     = hit0 | hit1;
        hit_way = ~hit0;
        line    = data_q[hit_way][index];
        rd_word = word_sel ? line[63:32] : line[31:0];
    end

    // Next-state of storage: fill replaces the LRU way, hits mark the other way as next victim
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        lru_d   = lru_q;
        victim  = lru_q[index];
        if (fill_en) begin
            valid_d[victim][index] = 1'b1;
            tag_d[victim][index]   = tag;
            data_d[victim][index]  = fill_line;
            lru_d[index]           = ~victim;
        end else if (wr_en || touch_en) begin
            lru_d[index] = ~hit_way;
            if (wr_en) data_d[hit_way][index][{word_sel, 5'd0} +: 32] = wr_word;
        end
    end

    // Valid and LRU bits are cleared by reset so every line starts invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: '0};
            lru_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
        end
    end

    // Tag and data arrays need no reset: they are only visible through valid
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way write-through no-write-allocate data cache in front of the SRAM controller (optional CACHE_STATS_EN adds hit/miss counters)
module cache_controller import cache_controller_pkg::*; (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [LEN_ADDRESS-1:0]    address,
    input  logic [LEN_REGISTER-1:0]   wdata,
    output logic [LEN_REGISTER-1:0]   rdata,
    output logic                      mem_ready,
    output logic                      sram_read,
    output logic                      sram_write,
    output logic [LEN_ADDRESS-1:0]    sram_address,
    output logic [LEN_REGISTER-1:0]   sram_wdata,
    input  logic [LEN_CACHE_LINE-1:0] sram_rdata,
    input  logic                      sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);
    state_e                  state_q, state_d;
    logic                    hit, hit_way, fill_en, wr_en, touch_en;
    logic [LEN_REGISTER-1:0] cache_word;

    cache_set_array u_set_array (
        .clk       (clk),
        .rst       (rst),
        .index     (address[8:3]),
        .tag       (address[18:9]),
        .word_sel  (address[2]),
        .fill_en   (fill_en),
        .fill_line (sram_rdata),
        .wr_en     (wr_en),
        .wr_word   (wdata),
        .touch_en  (touch_en),
        .hit       (hit),
        .hit_way   (hit_way),
        .rd_word   (cache_word)
    );

    assign sram_address = address;
    assign sram_wdata   = wdata;

    // FSM next-state and outputs; a simultaneous read+write is taken as a write
    always_comb begin
        state_d    = state_q;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        mem_ready  = 1'b1;
        rdata      = '0;
        fill_en    = 1'b0;
        wr_en      = 1'b0;
        touch_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    mem_ready = 1'b0;
                    state_d   = WRITE;
                end else if (mem_read && hit) begin
                    rdata    = cache_word;
                    touch_en = 1'b1;
                end else if (mem_read) begin
                    mem_ready = 1'b0;
                    state_d   = READ_MISS;
                end
            end
            READ_MISS: begin
                sram_read = 1'b1;
                mem_ready = sram_ready;
                if (sram_ready) begin
                    fill_en = 1'b1;
                    rdata   = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                    state_d = IDLE;
                end
            end
            WRITE: begin
                sram_write = 1'b1;
                mem_ready  = sram_ready;
                if (sram_ready) begin
                    wr_en   = hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight SRAM transaction
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    // Saturating counters: hits on accepted read hits, misses on read-miss completion
    always_comb begin
        hit_count_d  = (touch_en && ~&hit_count_q)  ? hit_count_q + 32'd1  : hit_count_q;
        miss_count_d = (fill_en  && ~&miss_count_q) ? miss_count_q + 32'd1 : miss_count_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule
